// File: rtl/gcd_seq.sv
// ---------------------------------------------------------------------------
// gcd_seq
//
// Subtractive GCD sequencer. Owns the two operand registers (A, B) and the
// subtract/compare logic, performs one subtraction per clock and reports the
// result, the number of subtractions and a zero-operand error flag through a
// start/ready handshake.
//
// Optional feature (compile-time macro GCD_ZERO_BYPASS_EN):
//   defined   : a zero operand yields result = A|B, err = 0
//               (gcd(0,x) = x, gcd(0,0) = 0)
//   undefined : a zero operand yields result = 0, err = 1
//   In both builds a zero operand finishes on the first RUN edge with iters = 0.
//
// Ports:
//   clk    in  1      rising-edge clock
//   reset  in  1      synchronous reset, active low
//   start  in  1      request, accepted only while ready = 1
//   a_in   in  WIDTH  operand A, sampled on the accepting edge
//   b_in   in  WIDTH  operand B, sampled on the accepting edge
//   ready  out 1      high in IDLE
//   done   out 1      one-cycle pulse when result/iters/err update
//   result out WIDTH  GCD, held until the next done
//   iters  out WIDTH  subtraction count (saturating), held until the next done
//   err    out 1      zero-operand error flag, held until the next done
// ---------------------------------------------------------------------------
module gcd_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] iters,
    output logic             err
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             a_en, b_en;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] iters_q, iters_d;
    logic             err_q, err_d;
    logic             done_q, done_d;

    // Saturating increment: the counter sticks at all-ones instead of wrapping.
    function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] one;
        one = {{(WIDTH-1){1'b0}}, 1'b1};
        return (&v) ? v : (v + one);
    endfunction

    // Next-state / datapath decode
    always_comb begin
        state_d  = state_q;
        a_en     = 1'b0;
        b_en     = 1'b0;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        iters_d  = iters_q;
        err_d    = err_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_en    = 1'b1;
                    b_en    = 1'b1;
                    a_d     = a_in;
                    b_d     = b_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end

            RUN: begin
                if ((a_q == '0) || (b_q == '0)) begin
                    // Zero operand: terminate immediately, never loop.
`ifdef GCD_ZERO_BYPASS_EN
                    result_d = a_q | b_q;
                    err_d    = 1'b0;
`else
                    result_d = '0;
                    err_d    = 1'b1;
`endif
                    iters_d  = '0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (a_q == b_q) begin
                    result_d = a_q;
                    err_d    = 1'b0;
                    iters_d  = cnt_q;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end else if (a_q > b_q) begin
                    // Larger value is always the minuend, so no underflow.
                    a_en  = 1'b1;
                    a_d   = a_q - b_q;
                    cnt_d = sat_inc(cnt_q);
                end else begin
                    b_en  = 1'b1;
                    b_d   = b_q - a_q;
                    cnt_d = sat_inc(cnt_q);
                end
            end

            default: state_d = IDLE;
        endcase
    end

    // State and register update
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            iters_q  <= '0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            if (a_en) a_q <= a_d;
            if (b_en) b_q <= b_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            iters_q  <= iters_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    // Outputs are registers or a direct state decode; no input-to-output paths.
    assign ready  = (state_q == IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign iters  = iters_q;
    assign err    = err_q;

endmodule

// File: tb/tb_gcd_seq.sv
// ---------------------------------------------------------------------------
// tb_gcd_seq
//
// Directed testbench for gcd_seq at WIDTH = 8. Expected values are worked out
// by hand from the subtractive GCD algorithm and its cycle timing. Works with
// and without GCD_ZERO_BYPASS_EN defined.
// ---------------------------------------------------------------------------
module tb_gcd_seq;

    localparam int WIDTH = 8;

    logic             clk;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] iters;
    logic             err;

    int n_checks = 0;
    int n_fail   = 0;

    gcd_seq #(.WIDTH(WIDTH)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .a_in   (a_in),
        .b_in   (b_in),
        .ready  (ready),
        .done   (done),
        .result (result),
        .iters  (iters),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Present a request and clock it in (edge E0); returns just after E0.
    task automatic issue(input int a, input int b);
        a_in  = WIDTH'(a);
        b_in  = WIDTH'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Count edges after E0 until done is seen; bounded.
    task automatic wait_done(input int from, output int edges);
        edges = from;
        while (!done && edges < 400) begin
            tick();
            edges++;
        end
    endtask

    int edges;
    int done_seen;

    initial begin
        reset = 1'b0;
        start = 1'b0;
        a_in  = '0;
        b_in  = '0;

        // Reset low for two cycles
        tick();
        tick();
        reset = 1'b1;
        check("rst_ready",  int'(ready),  1);
        check("rst_done",   int'(done),   0);
        check("rst_result", int'(result), 0);
        check("rst_iters",  int'(iters),  0);
        check("rst_err",    int'(err),    0);
        tick();
        check("idle_ready", int'(ready), 1);
        check("idle_done",  int'(done),  0);

        // (12,8): A/B 12/8 -> 4/8 -> 4/4, done after E0+3
        issue(12, 8);
        check("g12_ready_low", int'(ready), 0);
        check("g12_a0", int'(dut.a_q), 12);
        check("g12_b0", int'(dut.b_q), 8);
        tick();
        check("g12_a1", int'(dut.a_q), 4);
        check("g12_b1", int'(dut.b_q), 8);
        check("g12_done1", int'(done), 0);
        tick();
        check("g12_a2", int'(dut.a_q), 4);
        check("g12_b2", int'(dut.b_q), 4);
        check("g12_done2", int'(done), 0);
        tick();
        check("g12_done3",  int'(done),   1);
        check("g12_ready3", int'(ready),  1);
        check("g12_result", int'(result), 4);
        check("g12_iters",  int'(iters),  2);
        check("g12_err",    int'(err),    0);
        tick();
        check("g12_pulse",  int'(done),   0);
        check("g12_hold",   int'(result), 4);

        // (7,7): done after E0+1, then back-to-back (1,255)
        issue(7, 7);
        wait_done(0, edges);
        check("g7_edges",  edges,         1);
        check("g7_result", int'(result),  7);
        check("g7_iters",  int'(iters),   0);
        check("g7_ready",  int'(ready),   1);
        a_in  = 8'd1;
        b_in  = 8'd255;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b_accept", int'(ready), 0);
        wait_done(0, edges);
        check("g1_edges",  edges,        255);
        check("g1_result", int'(result), 1);
        check("g1_iters",  int'(iters),  254);
        check("g1_err",    int'(err),    0);
        tick();

        // (0,9): zero operand
        issue(0, 9);
        wait_done(0, edges);
        check("z9_edges", edges, 1);
        check("z9_iters", int'(iters), 0);
`ifdef GCD_ZERO_BYPASS_EN
        check("z9_result", int'(result), 9);
        check("z9_err",    int'(err),    0);
`else
        check("z9_result", int'(result), 0);
        check("z9_err",    int'(err),    1);
`endif
        tick();

        // (0,0)
        issue(0, 0);
        wait_done(0, edges);
        check("z0_edges",  edges,        1);
        check("z0_result", int'(result), 0);
        check("z0_iters",  int'(iters),  0);
`ifdef GCD_ZERO_BYPASS_EN
        check("z0_err", int'(err), 0);
`else
        check("z0_err", int'(err), 1);
`endif
        tick();

        // (200,3) with an ignored (5,5) request mid-run
        issue(200, 3);
        tick();
        tick();
        a_in  = 8'd5;
        b_in  = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ign_ready", int'(ready), 0);
        check("ign_done",  int'(done),  0);
        wait_done(3, edges);
        check("g200_edges",  edges,        69);
        check("g200_result", int'(result), 1);
        check("g200_iters",  int'(iters),  68);
        check("g200_err",    int'(err),    0);
        tick();

        // (200,3) aborted by reset at E0+10
        issue(200, 3);
        for (int i = 0; i < 9; i++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("abort_ready",  int'(ready),  1);
        check("abort_done",   int'(done),   0);
        check("abort_result", int'(result), 0);
        check("abort_iters",  int'(iters),  0);
        check("abort_err",    int'(err),    0);
        check("abort_a",      int'(dut.a_q), 0);
        done_seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_ready_after", int'(ready), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gcd_seq.md
# gcd_seq

Sequencer for the subtractive-GCD datapath. Owns two enable-loaded operand registers (A, B) and the subtract/compare logic. Runs a start/ready handshake with the host and reports result, iteration count and error, one subtraction per clock. Sits between the top-level stimulus/host logic and the operand register bank.

## Interface
- `WIDTH`, 32, operand/result width in bits (≥2).
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: synchronous, active-low; sampled on `clk` rising edge.
- `start` in 1: request; accepted only on an edge where `ready`=1.
- `a_in` in WIDTH: operand A, sampled on the accepting edge.
- `b_in` in WIDTH: operand B, sampled on the accepting edge.
- `ready` out 1: high in IDLE; low while a computation runs.
- `done` out 1: one-cycle pulse when `result`, `iters` and `err` update.
- `result` out WIDTH: GCD; held until the next `done`.
- `iters` out WIDTH: number of subtractions performed; held until the next `done`.
- `err` out 1: error flag for zero operands (see Configuration); held until the next `done`.

## Operation
- States: IDLE, RUN.
- IDLE, `start`=1:
  - A<=`a_in`, B<=`b_in`, iteration counter<=0, state<=RUN.
  - `start`=0: registers hold; the operand-register enables stay deasserted.
- RUN, one decision per edge, in priority order:
  1. A==0 or B==0: zero handling (Configuration); `done`<=1; state<=IDLE.
  2. A==B: `result`<=A, `err`<=0, `iters`<=counter, `done`<=1, state<=IDLE.
  3. A>B: A<=A−B; B holds; counter+1.
  4. A<B: B<=B−A; A holds; counter+1.
- Only one operand register is enabled per RUN edge; the other holds.
- Arithmetic is unsigned WIDTH-bit. The subtraction never underflows because the larger value is always the minuend.
- Counter saturates at 2^WIDTH−1 and does not wrap.
- `start` while `ready`=0 is ignored; there is no queueing.
- `done` is 1 for exactly one cycle. It is 0 on every edge that does not take branch 1 or 2.
- `ready`=1 in the same cycle `done`=1, so a `start` in that cycle is accepted (back-to-back operation).
- Reset (any state, including mid-RUN):
  - state=IDLE, A=B=0, counter=0, `result`=0, `iters`=0, `err`=0, `done`=0.
  - `ready`=1 from the first edge with `reset`=0 onward.
  - The aborted computation produces no `done`.

## Timing
- Accepting edge E0. With k subtractions, `done` is high in the cycle after edge E0+k+1.
- Equal nonzero operands: k=0, `done` after E0+1.
- Zero operand: `done` after E0+1, `iters`=0.
- `result`/`iters`/`err` change only on the edge that raises `done`.
- `ready` falls the cycle after E0 and rises together with `done`.
- All outputs are registered or decoded directly from state; there are no combinational paths from inputs to outputs.

## Configuration
- Macro: `GCD_ZERO_BYPASS_EN`.
- Defined: a zero operand gives `result`<=A|B, `err`<=0, `iters`<=0. This yields gcd(0,x)=x and gcd(0,0)=0.
- Undefined: a zero operand gives `result`<=0, `err`<=1, `iters`<=0.
- Both builds never loop on zero inputs.

## Test plan
- WIDTH=8, reset low 2 cycles, then high:
  - `ready`=1, `done`=0, `result`=0, `iters`=0, `err`=0.
- (12,8) at E0:
  - A/B sequence 12/8 → 4/8 → 4/4.
  - `done` after E0+3; `result`=4, `iters`=2, `err`=0.
- (7,7):
  - `done` after E0+1; `result`=7, `iters`=0.
  - `start` held high in the `done` cycle with (1,255) is accepted.
  - Then `done` after 255 edges; `result`=1, `iters`=254.
- (0,9):
  - With `GCD_ZERO_BYPASS_EN`: `result`=9, `err`=0.
  - Without it: `result`=0, `err`=1.
  - Both: `done` after E0+1.
- (0,0) with the macro defined: `result`=0, `err`=0, `iters`=0.
- (200,3), then `start` pulsed with (5,5) during RUN:
  - The second request is ignored; the first completes with `result`=1, `iters`=68.
  - Repeat (200,3), this time pulling `reset` low at E0+10: no `done` ever follows, all outputs read 0, and `ready`=1 the cycle after.
